// File: rtl/keypad_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// keypad_pkg : key codes, opcodes, scan state type and matrix helpers
// Rev 1.0
// ---------------------------------------------------------------------------
package keypad_pkg;

  localparam int NUM_ROWS = 6;
  localparam int NUM_COLS = 4;

  localparam logic [4:0] KEY_ADD = 5'd16;
  localparam logic [4:0] KEY_SUB = 5'd17;
  localparam logic [4:0] KEY_MUL = 5'd18;
  localparam logic [4:0] KEY_EQ  = 5'd19;
  localparam logic [4:0] KEY_BS  = 5'd20;
  localparam logic [4:0] KEY_CE  = 5'd21;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    HOLD     = 2'd3
  } kp_state_t;

  function automatic logic single_low(input logic [3:0] c);
    return ($countones(~c) == 1);
  endfunction

  function automatic logic [1:0] low_col(input logic [3:0] c);
    logic [1:0] col;
    col = 2'd0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (!c[i]) col = 2'(i);
    end
    return col;
  endfunction

  function automatic logic [2:0] next_row(input logic [2:0] row);
    return (row == 3'(NUM_ROWS - 1)) ? 3'd0 : row + 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/kp_col_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// kp_col_sync : 2-flop synchroniser for the active-low column inputs
// Rev 1.0
// ---------------------------------------------------------------------------
module kp_col_sync (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  // Idle (no key) level is all ones, so reset there to avoid a phantom press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= 4'hF;
      q    <= 4'hF;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// keypad_encoder : 6x4 matrix scan, debounce and one-strobe-per-press decode
// Optional auto-repeat for hex/BS keys: define KEY_REPEAT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] cols_n,
  output logic [5:0] rows_n,
  output logic       newhex,
  output logic [3:0] hexcode,
  output logic       newop,
  output logic [1:0] opcode,
  output logic       eq,
  output logic       BS,
  output logic       CE
);

  localparam int BASE_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
`ifdef KEY_REPEAT_EN
  localparam int MAX_CYCLES = (REPEAT_CYCLES > BASE_MAX) ? REPEAT_CYCLES : BASE_MAX;
`else
  localparam int MAX_CYCLES = BASE_MAX;
`endif
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (SETTLE_CYCLES < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("keypad_encoder: cycle parameters must be at least 1");
  end

  kp_state_t        state, state_nx;
  logic [2:0]       row, row_nx;
  logic [CNT_W-1:0] settle_cnt, settle_nx;
  logic [CNT_W-1:0] stab_cnt, stab_nx;
  logic [3:0]       cs;
  logic [3:0]       cap_pat, cap_pat_nx;
  logic [4:0]       code, code_nx;
  logic             load_key;
  logic             fire;
  logic             rep_fire;

  kp_col_sync u_sync (
    .clock (clock),
    .reset (reset),
    .d     (cols_n),
    .q     (cs)
  );

  assign rows_n = ~(6'd1 << row);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= SCAN;
      row        <= 3'd0;
      settle_cnt <= '0;
      stab_cnt   <= '0;
      cap_pat    <= 4'hF;
      code       <= 5'd0;
    end else begin
      state      <= state_nx;
      row        <= row_nx;
      settle_cnt <= settle_nx;
      stab_cnt   <= stab_nx;
      cap_pat    <= cap_pat_nx;
      code       <= code_nx;
    end
  end

  // stab_cnt counts matching cycles in DEBOUNCE and released cycles in HOLD.
  always_comb begin
    state_nx   = state;
    row_nx     = row;
    settle_nx  = settle_cnt;
    stab_nx    = stab_cnt;
    cap_pat_nx = cap_pat;
    code_nx    = code;
    case (state)
      SCAN: begin
        if (settle_cnt == SETTLE_LAST) begin
          settle_nx = '0;
          if (single_low(cs)) begin
            state_nx   = DEBOUNCE;
            cap_pat_nx = cs;
            code_nx    = {row, low_col(cs)};
            stab_nx    = '0;
          end else begin
            row_nx = next_row(row);
          end
        end else begin
          settle_nx = settle_cnt + CNT_ONE;
        end
      end
      DEBOUNCE: begin
        if (cs != cap_pat) begin
          state_nx  = SCAN;
          stab_nx   = '0;
          settle_nx = '0;
        end else if (stab_cnt == DEB_LAST) begin
          state_nx = EMIT;
          stab_nx  = '0;
        end else begin
          stab_nx = stab_cnt + CNT_ONE;
        end
      end
      EMIT: begin
        state_nx = HOLD;
        stab_nx  = '0;
      end
      HOLD: begin
        if (cs != 4'hF) begin
          stab_nx = '0;
        end else if (stab_cnt == DEB_LAST) begin
          state_nx  = SCAN;
          stab_nx   = '0;
          settle_nx = '0;
          row_nx    = next_row(row);
        end else begin
          stab_nx = stab_cnt + CNT_ONE;
        end
      end
      default: state_nx = SCAN;
    endcase
  end

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] rep_cnt;
  logic             key_low;
  logic             repeatable;

  assign key_low    = ~cs[code[1:0]];
  assign repeatable = ~code[4] | (code == KEY_BS);
  assign rep_fire   = (state == HOLD) && key_low && repeatable && (rep_cnt == REP_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rep_cnt <= '0;
    end else if ((state != HOLD) || !key_low || rep_fire) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + CNT_ONE;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Latch the digit/operator on entry to EMIT so it is valid with its strobe.
  assign load_key = (state == DEBOUNCE) && (state_nx == EMIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hexcode <= 4'd0;
      opcode  <= OP_ADD;
    end else if (load_key) begin
      if (!code[4]) begin
        hexcode <= code[3:0];
      end else begin
        case (code)
          KEY_ADD: opcode <= OP_ADD;
          KEY_SUB: opcode <= OP_SUB;
          KEY_MUL: opcode <= OP_MUL;
          default: ;
        endcase
      end
    end
  end

  assign fire = (state == EMIT) || rep_fire;

  always_comb begin
    newhex = 1'b0;
    newop  = 1'b0;
    eq     = 1'b0;
    BS     = 1'b0;
    CE     = 1'b0;
    if (fire) begin
      if (!code[4]) begin
        newhex = 1'b1;
      end else begin
        case (code)
          KEY_ADD, KEY_SUB, KEY_MUL: newop = 1'b1;
          KEY_EQ:  eq = 1'b1;
          KEY_BS:  BS = 1'b1;
          KEY_CE:  CE = 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/keypad_encoder.md
Name: keypad_encoder

Overview:
- Scans the calculator's 6x4 key matrix, debounces key presses and reports each press once.
- Emits exactly one single-cycle strobe per press on the key-event interface the calculator register block consumes: newhex + hexcode, newop + opcode, eq, BS, CE.
- Sits between the board key matrix pins and the register/ALU datapath.

Parameters:
- SETTLE_CYCLES, 16: cycles a row is driven before its columns are sampled.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a press or a release (1 ms at 50 MHz).
- REPEAT_CYCLES, 12500000: auto-repeat period; used only when KEY_REPEAT_EN is defined.

Ports:
- clock  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- cols_n  in  4  matrix columns, active-low, asynchronous to clock.
- rows_n  out  6  matrix row drive, active-low, exactly one bit low at all times.
- newhex  out  1  one-cycle strobe: hex key pressed.
- hexcode  out  4  hex digit; valid in the newhex cycle and held until the next hex press.
- newop  out  1  one-cycle strobe: operator key pressed.
- opcode  out  2  00 add, 01 sub, 10 mul; valid with newop and held until the next operator press.
- eq  out  1  one-cycle strobe: equals key.
- BS  out  1  one-cycle strobe: backspace key.
- CE  out  1  one-cycle strobe: clear-entry key.

Behaviour:
- Reset (async assert, sync deassert):
  - rows_n = 6'b111110 (row 0 driven); all strobes 0; hexcode 0; opcode 0.
  - State SCAN; all counters 0; synchroniser flops = 4'b1111.
- cols_n passes through a 2-flop synchroniser. All timings below refer to the synchronised value cs.
- Key code = row*4 + col.
  - Codes 0-15 are hex digits; hexcode = code.
  - 16 add, 17 sub, 18 mul, 19 eq, 20 BS, 21 CE.
  - 22 and 23 are unused: no strobe, but still go through HOLD.
- SCAN:
  - Drive the current row for SETTLE_CYCLES cycles, then sample cs.
  - cs == 4'b1111: advance to the next row, wrapping 5 to 0, and restart settle.
  - Exactly one cs bit low: capture row and column, go to DEBOUNCE, keep the row driven.
  - Two or more bits low (ghost or multi-press): ignore and advance to the next row.
- DEBOUNCE:
  - Each cycle, compare cs to the captured pattern and count matching cycles.
  - Any mismatch: clear the count and return to SCAN on the same row, restarting settle.
  - Count reaches DEBOUNCE_CYCLES: go to EMIT.
- EMIT (1 cycle):
  - Assert exactly one strobe according to the key map.
  - Update hexcode or opcode in the same cycle as its strobe.
  - Go to HOLD.
- HOLD:
  - Keep the row driven; count cycles with cs == 4'b1111; any low bit clears the count.
  - Count reaches DEBOUNCE_CYCLES: go to SCAN on the next row.
  - No repeat unless KEY_REPEAT_EN is defined.
- Never assert more than one strobe per cycle.
- Never produce a strobe while reset is high.
- A second key pressed during HOLD is ignored until all keys are released.
- Reset asserted mid-DEBOUNCE or mid-HOLD aborts immediately; no strobe is produced.
- Press-to-strobe latency (held key, row already driven, settle elapsed) = 2 (sync) + 1 (sample) + DEBOUNCE_CYCLES + 1 cycles.
- Counter widths are clog2 of the largest parameter in use.

Optional Feature:
- Macro KEY_REPEAT_EN.
- Defined:
  - In HOLD with the captured key still low, a second counter re-asserts the key's strobe for one cycle every REPEAT_CYCLES.
  - Applies to BS and hex keys only; operator, eq and CE keys never repeat.
  - Release returns the block to the normal release debounce.
- Undefined: the repeat counter and its logic are absent; exactly one strobe per press.

Decomposition:
- Package keypad_pkg holds:
  - the key code localparams (KEY_ADD=16 through KEY_CE=21);
  - the opcode constants OP_ADD, OP_SUB and OP_MUL;
  - the state enum SCAN, DEBOUNCE, EMIT, HOLD.
- Sub-module kp_col_sync: the 4-bit 2-flop synchroniser with async reset to 4'b1111.
- Scan FSM, counters and key decode stay in keypad_encoder.

Test Plan (SETTLE_CYCLES=2, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20):
- Press key row 1, col 2 (cols_n=4'b1011 while rows_n=6'b111101) and hold 40 cycles -> exactly one newhex pulse with hexcode=4'h6; all other strobes 0.
- Press row 4, col 1 (code 17) -> one newop pulse with opcode=2'b01; opcode holds 01 after release.
- Bounce row 4, col 3 low/high every 2 cycles for 20 cycles, then stable low -> no strobe during bounce; exactly one eq (code 19) after 4 stable cycles.
- Drive cols_n=4'b0011 on row 0 -> no strobe; scan continues through rows 1-5 and wraps to row 0.
- Assert reset for 1 cycle mid-DEBOUNCE on BS (row 5, col 0) -> no BS pulse; rows_n=6'b111110 immediately; all outputs 0.
- With KEY_REPEAT_EN, hold BS for 70 cycles -> BS pulses at press plus 3 repeats 20 cycles apart; without the macro, exactly 1 pulse.
